// File: rtl/capture_buffered.sv
// capture_buffered: divided-rate sampler with pre/post trigger ring buffer drained over AXI-Stream
module capture_buffered #(
  parameter int SIZE = 32,
  parameter int MAX_DIV = 32,
  parameter int DEPTH = 256,
  parameter int CNT_W = 24,
  localparam int DIV_W = $clog2(MAX_DIV),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] ckdiv,
  input  logic [SIZE-1:0]  dinput,
  input  logic             arm,
  input  logic             abort,
  input  logic [SIZE-1:0]  trig_mask,
  input  logic [SIZE-1:0]  trig_type,
  input  logic [SIZE-1:0]  trig_level,
  input  logic [AW-1:0]    pre_count,
  input  logic [CNT_W-1:0] post_count,
  output logic [SIZE-1:0]  tdata,
  output logic             tvalid,
  input  logic             tready,
  output logic             tlast,
  output logic             sample_stb,
  output logic             armed,
  output logic             triggered,
  output logic             done,
  output logic             overrun
);
  localparam int OW = AW + 1;
  typedef enum logic [1:0] {IDLE, ARMED, POST, FLUSH} state_t;
  state_t state, state_nx;
  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, pre_l;
  logic [AW:0] occ;
  logic [DIV_W-1:0] div_cnt, div_q;
  logic [CNT_W-1:0] post_l, post_cnt;
  logic [SIZE-1:0] mask_l, type_l, level_l, prev, em;
  logic have_prev, accept, restart, wrap, xfer, full, hit, wr_en, rd_adv, drop, post_stb;
  assign accept = state == IDLE && arm && !abort;
  assign restart = ckdiv != div_q || accept;
  assign wrap = !restart && div_cnt == ckdiv;
  assign armed = state == ARMED;
  assign triggered = state == POST || state == FLUSH;
  assign tvalid = triggered && occ != '0;
  assign tdata = mem[rd_ptr];
  assign tlast = state == FLUSH && occ == OW'(1);
  assign xfer = tvalid && tready;
  assign full = occ - OW'(xfer) == OW'(DEPTH);
  assign em = mask_l & type_l;
  assign hit = ~|((dinput ^ level_l) & mask_l) && ~|(~(dinput ^ prev) & em) && (have_prev || ~|em);
  assign post_stb = sample_stb && state == POST && !abort;
  assign wr_en = sample_stb && (state == ARMED || (state == POST && !full));
  assign drop = post_stb && full;
  assign rd_adv = xfer || (sample_stb && state == ARMED && !hit && occ == {1'b0, pre_l});
  // next-state: abort wins, then arm, trigger, post countdown and final transfer
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else if (accept) state_nx = ARMED;
    else if (state == ARMED && sample_stb && hit) state_nx = post_l == '0 ? FLUSH : POST;
    else if (post_stb && post_cnt == CNT_W'(1)) state_nx = FLUSH;
    else if (xfer && tlast) state_nx = IDLE;
  end
  // state register
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nx;
  // sample storage; contents are don't-care until written
  always_ff @(posedge clk) if (wr_en) mem[wr_ptr] <= dinput;
  // divider, ring pointers, latched trigger setup, post counter and status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      div_q <= '0;
      sample_stb <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      pre_l <= '0;
      post_l <= '0;
      post_cnt <= '0;
      mask_l <= '0;
      type_l <= '0;
      level_l <= '0;
      prev <= '0;
      have_prev <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      div_q <= ckdiv;
      div_cnt <= restart || wrap ? '0 : div_cnt + 1'b1;
      sample_stb <= wrap;
      if (abort || accept) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ <= '0;
        done <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr + AW'(wr_en);
        rd_ptr <= rd_ptr + AW'(rd_adv);
        occ <= occ + OW'(wr_en) - OW'(rd_adv);
        if (drop) overrun <= 1'b1;
        if (xfer && tlast) done <= 1'b1;
      end
      if (accept) begin
        mask_l <= trig_mask;
        type_l <= trig_type;
        level_l <= trig_level;
        post_l <= post_count;
        pre_l <= pre_count;
        have_prev <= 1'b0;
        overrun <= 1'b0;
      end
      if (state == ARMED && sample_stb && !abort) begin
        prev <= dinput;
        have_prev <= 1'b1;
      end
      if (state == ARMED && sample_stb && hit && !abort) post_cnt <= post_l;
      else if (post_stb) post_cnt <= post_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_capture_buffered.sv
// tb_capture_buffered: directed vector table plus hand-built multi-cycle scenarios
module tb_capture_buffered;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] ckdiv = '0;
  logic [15:0] dinput = '0;
  logic arm = 1'b0;
  logic abort = 1'b0;
  logic [15:0] trig_mask = '0;
  logic [15:0] trig_type = '0;
  logic [15:0] trig_level = '0;
  logic [2:0] pre_count = '0;
  logic [7:0] post_count = 8'd3;
  logic [15:0] tdata;
  logic tvalid;
  logic tready = 1'b1;
  logic tlast, sample_stb, armed, triggered, done, overrun;
  int checks = 0;
  int errors = 0;
  logic [15:0] got_d[$];
  logic got_l[$];
  typedef struct {
    logic rst_n, arm;
    logic [15:0] din;
    logic stb, vld, last, arm_o, trg, dn;
    logic [15:0] data;
  } vec_t;
  vec_t vq[$];

  capture_buffered #(.SIZE(16), .MAX_DIV(32), .DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ckdiv(ckdiv), .dinput(dinput), .arm(arm), .abort(abort),
    .trig_mask(trig_mask), .trig_type(trig_type), .trig_level(trig_level),
    .pre_count(pre_count), .post_count(post_count), .tdata(tdata), .tvalid(tvalid),
    .tready(tready), .tlast(tlast), .sample_stb(sample_stb), .armed(armed),
    .triggered(triggered), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic a, input logic [15:0] d, input logic s,
                     input logic v, input logic l, input logic ao, input logic t,
                     input logic dn, input logic [15:0] x);
    vq.push_back('{r, a, d, s, v, l, ao, t, dn, x});
  endtask

  task automatic collect(input int budget, input bit inc);
    got_d.delete();
    got_l.delete();
    for (int i = 0; i < budget && !done; i++) begin
      if (tvalid && tready) begin
        got_d.push_back(tdata);
        got_l.push_back(tlast);
      end
      if (inc) dinput = dinput + 16'd1;
      tick();
    end
  endtask

  task automatic chk_stream(input string nm, input logic [15:0] first, input int n);
    int lasts;
    lasts = 0;
    chk({nm, "_count"}, got_d.size(), n);
    foreach (got_d[i]) begin
      chk($sformatf("%s_word%0d", nm, i), got_d[i], first + 16'(i));
      lasts += int'(got_l[i]);
    end
    chk({nm, "_tlast_count"}, lasts, 1);
    if (got_l.size() > 0) chk({nm, "_tlast_final"}, got_l[got_l.size()-1], 1);
    chk({nm, "_done"}, done, 1);
  endtask

  initial begin
    int n;
    bit found;
    // scenario 1 cycle table: ckdiv=0, no trigger mask, pre=0, post=3, tready=1
    add(0, 0, 16'd0,   0, 0, 0, 0, 0, 0, 16'd0);
    add(1, 0, 16'd0,   1, 0, 0, 0, 0, 0, 16'd0);
    add(1, 1, 16'd100, 0, 0, 0, 1, 0, 0, 16'd0);
    add(1, 0, 16'd101, 1, 0, 0, 1, 0, 0, 16'd0);
    add(1, 0, 16'd102, 1, 1, 0, 0, 1, 0, 16'd102);
    add(1, 0, 16'd103, 1, 1, 0, 0, 1, 0, 16'd103);
    add(1, 0, 16'd104, 1, 1, 0, 0, 1, 0, 16'd104);
    add(1, 0, 16'd105, 1, 1, 1, 0, 1, 0, 16'd105);
    add(1, 0, 16'd106, 1, 0, 0, 0, 0, 1, 16'd0);
    add(1, 0, 16'd107, 1, 0, 0, 0, 0, 1, 16'd0);
    foreach (vq[i]) begin
      reset = vq[i].rst_n;
      arm = vq[i].arm;
      dinput = vq[i].din;
      tick();
      chk($sformatf("v%0d_stb", i), sample_stb, vq[i].stb);
      chk($sformatf("v%0d_tvalid", i), tvalid, vq[i].vld);
      chk($sformatf("v%0d_tlast", i), tlast, vq[i].last);
      chk($sformatf("v%0d_armed", i), armed, vq[i].arm_o);
      chk($sformatf("v%0d_triggered", i), triggered, vq[i].trg);
      chk($sformatf("v%0d_done", i), done, vq[i].dn);
      chk($sformatf("v%0d_overrun", i), overrun, 0);
      if (vq[i].vld) chk($sformatf("v%0d_tdata", i), tdata, vq[i].data);
    end
    arm = 1'b0;

    // scenario 2: counting input, keep 4 pre-trigger samples, level trigger on 10
    trig_mask = 16'hFFFF;
    trig_type = 16'h0000;
    trig_level = 16'd10;
    pre_count = 3'd4;
    post_count = 8'd2;
    dinput = 16'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    collect(60, 1);
    chk_stream("s2", 16'd6, 7);

    // scenario 3: rising edge on bit0, bit0 high at first strobe must not fire
    trig_mask = 16'h0001;
    trig_type = 16'h0001;
    trig_level = 16'h0001;
    pre_count = 3'd0;
    post_count = 8'd0;
    tready = 1'b0;
    dinput = 16'h0011;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    dinput = 16'h0021;
    tick();
    chk("s3_first_strobe_no_edge", triggered, 0);
    dinput = 16'h0031;
    tick();
    chk("s3_steady_high", triggered, 0);
    dinput = 16'h0040;
    tick();
    chk("s3_low", triggered, 0);
    dinput = 16'h0051;
    tick();
    chk("s3_rise_triggers", triggered, 1);
    chk("s3_tvalid", tvalid, 1);
    chk("s3_tdata", tdata, 16'h0051);
    chk("s3_tlast", tlast, 1);
    tready = 1'b1;
    tick();
    chk("s3_done", done, 1);

    // scenario 4: 20 post samples into an 8-deep buffer with the sink stalled
    trig_mask = 16'h0000;
    post_count = 8'd20;
    tready = 1'b0;
    dinput = 16'h0100;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("s4_arm_clears_done", done, 0);
    for (int k = 1; k < 30; k++) begin
      dinput = 16'h0100 + 16'(k);
      tick();
    end
    chk("s4_overrun", overrun, 1);
    chk("s4_tvalid_stalled", tvalid, 1);
    chk("s4_tlast_not_yet", tlast, 0);
    chk("s4_tdata_held", tdata, 16'h0102);
    tready = 1'b1;
    collect(30, 0);
    chk_stream("s4", 16'h0102, 8);
    chk("s4_overrun_kept", overrun, 1);

    // scenario 6: arm ignored in POST, abort with 5 words buffered, then immediate re-arm
    tready = 1'b0;
    dinput = 16'h0200;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("s6_arm_clears_overrun", overrun, 0);
    for (int k = 1; k < 6; k++) begin
      dinput = 16'h0200 + 16'(k);
      tick();
    end
    arm = 1'b1;
    dinput = 16'h0206;
    tick();
    chk("s6_arm_ignored_armed", armed, 0);
    chk("s6_arm_ignored_trig", triggered, 1);
    chk("s6_tdata_first", tdata, 16'h0202);
    abort = 1'b1;
    tick();
    chk("s6_abort_armed", armed, 0);
    chk("s6_abort_trig", triggered, 0);
    chk("s6_abort_tvalid", tvalid, 0);
    chk("s6_abort_done", done, 0);
    abort = 1'b0;
    post_count = 8'd0;
    dinput = 16'h0ABC;
    tick();
    chk("s6_rearm", armed, 1);
    arm = 1'b0;
    tick();
    tick();
    chk("s6_single_word_tvalid", tvalid, 1);
    chk("s6_single_word_tlast", tlast, 1);
    chk("s6_single_word_tdata", tdata, 16'h0ABC);
    tready = 1'b1;
    tick();
    chk("s6_done", done, 1);

    // reset in the middle of a capture drops everything
    post_count = 8'd20;
    tready = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("rst_pre_overrun", overrun, 1);
    reset = 1'b0;
    tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_stb", sample_stb, 0);
    reset = 1'b1;
    tready = 1'b1;
    tick();
    chk("rst_after_tvalid", tvalid, 0);
    chk("rst_after_done", done, 0);

    // scenario 5: ckdiv=3 gives period 4, a ckdiv change restarts the count
    ckdiv = 5'd3;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      found = sample_stb;
    end
    chk("s5_strobe_seen", found, 1);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!sample_stb && n < 12);
      chk($sformatf("s5_period%0d", r), n, 4);
    end
    tick();
    ckdiv = 5'd2;
    for (int j = 0; j < 7; j++) begin
      tick();
      chk($sformatf("s5_restart_c%0d", j), sample_stb, (j == 3 || j == 6) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/capture_buffered.md
CAPTURE_BUFFERED -- requirements
Module: capture_buffered

Interface
REQ-001 Parameter SIZE, default 32: sample and stream data width.
REQ-002 Parameter MAX_DIV, default 32: divider range; DIV_W = $clog2(MAX_DIV).
REQ-003 Parameter DEPTH, default 256 (power of 2): sample buffer depth; AW = $clog2(DEPTH).
REQ-004 Parameter CNT_W, default 24: post-trigger counter width.
REQ-005 Ports, in order (name, direction, width, meaning):
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-low reset.
- ckdiv  in  DIV_W  sample strobe every ckdiv+1 clk cycles.
- dinput  in  SIZE  sampled data.
- arm  in  1  start capture; level-sensitive; accepted in IDLE only.
- abort  in  1  cancel capture from any state.
- trig_mask  in  SIZE  1 = bit participates in the trigger.
- trig_type  in  SIZE  0 = level match, 1 = edge match.
- trig_level  in  SIZE  required bit value, or value after the edge.
- pre_count  in  AW  pre-trigger samples to retain.
- post_count  in  CNT_W  samples after the trigger sample.
- tdata  out  SIZE  AXI-Stream data.
- tvalid  out  1  AXI-Stream valid.
- tready  in  1  AXI-Stream ready.
- tlast  out  1  final word of the capture.
- sample_stb  out  1  one-cycle sample strobe.
- armed  out  1  in ARMED state.
- triggered  out  1  in POST or FLUSH state.
- done  out  1  last capture completed.
- overrun  out  1  sticky: a sample was dropped because the buffer was full.

Function
REQ-006 Divider: the counter runs 0..ckdiv; sample_stb is high for one cycle at wrap. ckdiv=0 gives a strobe every cycle. The counter restarts at 0 when ckdiv changes or when arm is accepted.
REQ-007 States are IDLE, ARMED, POST and FLUSH. The buffer is circular, holding DEPTH entries, with wr_ptr, rd_ptr and an (AW+1)-bit occupancy count.
REQ-008 IDLE->ARMED on arm:
- Latch trig_mask, trig_type, trig_level, post_count.
- Latch pre_count, clamped to DEPTH-1.
- Flush the buffer; clear done and overrun.
REQ-009 ARMED, on each strobe:
- Write dinput to the buffer.
- If occupancy already equals the latched pre_count, advance rd_ptr in the same cycle, discarding the oldest sample.
- tvalid stays 0.
REQ-010 Trigger, evaluated on each ARMED strobe against dinput and the previous sample:
- Masked level bits: value equals level.
- Masked edge bits: value differs from the previous sample and equals level.
- The first ARMED strobe has no previous sample; edge bits do not match on it.
- trig_mask=0 triggers on the first ARMED strobe.
REQ-011 On a trigger hit:
- The trigger sample is written without discard.
- Move to POST; post counter = latched post_count.
- If post_count=0, move directly to FLUSH.
REQ-012 POST, on each strobe:
- Write the sample if not full and decrement the counter.
- If full, drop the sample, set overrun, and still decrement.
- At counter 0 -> FLUSH.
REQ-013 Stream output:
- tvalid = (POST or FLUSH) and occupancy>0; tdata = buffer[rd_ptr], read combinationally.
- A transfer happens on tvalid&&tready and advances rd_ptr.
- In the same cycle as a transfer, a write is also accepted: full is judged on occupancy after the read.
- A word written on cycle N is first visible on tvalid at N+1.
REQ-014 tvalid, tdata and tlast hold stable while tvalid&&!tready.
REQ-015 tlast = FLUSH and occupancy==1.
REQ-016 FLUSH->IDLE on the tlast transfer, which sets done=1. done holds until the next accepted arm, abort, or reset.
REQ-017 abort (priority over all other events) -> IDLE: flush the buffer, done=0, overrun retained, tvalid deasserts next cycle. arm is ignored while abort is high.
REQ-018 arm outside IDLE is ignored.

Reset
REQ-019 While reset=0 at a clk edge, on the following cycle:
- State=IDLE; pointers, occupancy, divider and post counter are all 0.
- sample_stb, tvalid, tlast, armed, triggered, done and overrun are all 0.
- Latched configuration is cleared to 0.
REQ-020 Reset mid-capture discards buffered data with no partial tlast.

Verification
REQ-021 Scenario 1:
- Stimulus: ckdiv=0, trig_mask=0, pre_count=0, post_count=3, tready=1.
- Response: exactly 4 words transferred, the 4th with tlast; then done=1.
REQ-022 Scenario 2:
- Stimulus: counter pattern on dinput, pre_count=4, post_count=2, level trigger on value 10.
- Response: stream is 6,7,8,9,10,11,12; tlast on 12.
REQ-023 Scenario 3:
- Stimulus: edge trigger on bit0 rising, dinput bit0 held 1 from arm, then 0, then 1.
- Response: trigger fires only on the 0->1 strobe.
REQ-024 Scenario 4:
- Stimulus: DEPTH=8, post_count=20, tready=0 until FLUSH.
- Response: overrun=1, exactly 8 words delivered, tlast on the 8th.
REQ-025 Scenario 5:
- Stimulus: ckdiv=3.
- Response: sample_stb period 4 clk cycles; changing ckdiv mid-run restarts the count from 0.
REQ-026 Scenario 6:
- Stimulus: abort asserted in POST with 5 words buffered.
- Response: IDLE next cycle, tvalid=0, done=0; a new arm is accepted immediately.
